// File: rtl/regfile_wr_arbiter.sv
// Purpose: small register file with two write requesters (round-robin arbitration)
//   and one combinational read port; cleared by a one-entry-per-cycle sweep after reset.
// Latency: a write is accepted in the same cycle it is granted and can be read back the next cycle.
//   The read port is combinational and shows the old value during a write (read-before-write).
// Backpressure: reqN_ready is combinational. It is low during the clear sweep and for the losing requester.
//   A requester keeps valid/addr/data stable until it sees ready.
// Ports:
//   clk, reset_l (sync, active-low)
//   req0_*/req1_* valid/addr/data in, ready out
//   rd_addr in, rd_data out
//   init_done, oob_err (1-cycle pulse), oob_count (saturating)
module regfile_wr_arbiter #(
  parameter int DEPTH = 7,
  parameter int DW    = 32,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          init_done,
  output logic          oob_err,
  output logic [7:0]    oob_count
);

  // Address comparisons are done one bit wider so that DEPTH == 2**AW still works.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx;        // clear-sweep index
  logic            prio;       // 0: favour requester 0, 1: favour requester 1
  logic [DW-1:0]   mem [DEPTH];

  logic            wr_fire;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_inb;

  // Next state and grant. Grants are also gated by reset_l.
  // This keeps a pending request from being accepted on a reset edge.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      INIT: begin
        if ({1'b0, idx} == LAST_W) state_nxt = RUN;
      end
      RUN: begin
        if (reset_l) begin
          req0_ready = req0_valid && (!req1_valid || !prio);
          req1_ready = req1_valid && (!req0_valid ||  prio);
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign wr_fire = req0_ready | req1_ready;
  assign wr_addr = req1_ready ? req1_addr : req0_addr;
  assign wr_data = req1_ready ? req1_data : req0_data;
  assign wr_inb  = ({1'b0, wr_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= INIT;
      idx       <= '0;
      prio      <= 1'b0;
      oob_err   <= 1'b0;
      oob_count <= 8'd0;
    end else begin
      state   <= state_nxt;
      oob_err <= wr_fire && !wr_inb;
      if (state == INIT) idx <= idx + 1'b1;
      // The winner moves to the back of the line. Idle cycles leave the order unchanged.
      if (wr_fire) prio <= req0_ready;
      if (wr_fire && !wr_inb && (oob_count != 8'hFF)) oob_count <= oob_count + 8'd1;
    end
  end

  // Storage has no reset. The sweep clears it, and during INIT idx is always below DEPTH.
  always_ff @(posedge clk) begin
    if (reset_l) begin
      if (state == INIT)          mem[idx]     <= '0;
      else if (wr_fire && wr_inb) mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data   = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
  assign init_done = (state == RUN);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  localparam int DEPTH = 7;
  localparam int DW    = 32;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr, rd_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] rd_data;
  logic          init_done, oob_err;
  logic [7:0]    oob_count;

  int checks = 0;
  int errors = 0;

  int            exp_gnt[$];
  logic [DW-1:0] exp_rd[$];
  logic          rd_chk = 1'b0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_l(reset_l),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .init_done(init_done), .oob_err(oob_err), .oob_count(oob_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake and every requested read is popped and compared here.
  always @(negedge clk) begin
    if (req0_ready && req1_ready) begin
      checks++;
      errors++;
      $display("FAIL dual_grant: got both readys high expected at most one");
    end else if (req0_ready || req1_ready) begin
      if (exp_gnt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got requester %0d expected none", req1_ready);
      end else begin
        chk("grant", 32'(req1_ready), 32'(exp_gnt.pop_front()));
      end
    end
    if (rd_chk) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_underflow: got rd_data %0h expected no read", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
  end

  task automatic rd(input int a, input logic [DW-1:0] e);
    rd_addr = AW'(a);
    exp_rd.push_back(e);
    rd_chk = 1'b1;
    @(posedge clk); #1;
    rd_chk = 1'b0;
  endtask

  task automatic wr0(input int a, input logic [DW-1:0] d);
    req0_valid = 1'b1;
    req0_addr  = AW'(a);
    req0_data  = d;
    exp_gnt.push_back(0);
    @(posedge clk); #1;
  endtask

  // Two reset edges with a request pending. Nothing may be granted and all flags must be clear.
  task automatic do_reset();
    reset_l    = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = '0;
    req0_data  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("ready0_in_reset", 32'(req0_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("init_done_reset", 32'(init_done), 0);
    chk("oob_err_reset",   32'(oob_err),   0);
    chk("oob_count_reset", 32'(oob_count), 0);
    @(posedge clk); #1;
    reset_l    = 1'b1;
    req0_valid = 1'b0;
  endtask

  // Requester 1 stays valid during the sweep, so any grant while in INIT is caught by the monitor.
  task automatic wait_init(input string name);
    int n = 0;
    req1_valid = 1'b1;
    req1_addr  = 3'd2;
    req1_data  = 32'hFFFF;
    while (!init_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req1_valid = 1'b0;
    chk(name, 32'(n), 7);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e [8];
    int k0, k1;
    logic g0, g1;

    reset_l    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = '0;
    req1_addr  = '0;
    req0_data  = '0;
    req1_data  = '0;
    rd_addr    = '0;

    // Reset, then the clear sweep; every entry and the out-of-range address must read 0.
    do_reset();
    wait_init("init_cycles");
    for (int a = 0; a < 8; a++) rd(a, '0);

    // Back-to-back writes from requester 0. Each one must be granted with no bubble.
    wr0(0, 32'd10);
    wr0(1, 32'd11);
    wr0(6, 32'd12);
    req0_valid = 1'b0;
    rd(0, 32'd10);
    rd(1, 32'd11);
    rd(6, 32'd12);
    rd(2, 32'd0);

    // Out-of-bounds write: handshake completes, one-cycle pulse, nothing is stored.
    wr0(7, 32'hDEAD);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("oob_err_pulse", 32'(oob_err),   1);
    chk("oob_count_1",   32'(oob_count), 1);
    @(negedge clk);
    chk("oob_err_clear", 32'(oob_err),   0);
    @(posedge clk); #1;
    e = '{32'd10, 32'd11, 32'd0, 32'd0, 32'd0, 32'd0, 32'd12, 32'd0};
    for (int a = 0; a < 8; a++) rd(a, e[a]);

    // The count saturates: 1 + 300 out-of-bounds writes gives 255.
    for (int i = 0; i < 300; i++) wr0(7, DW'(i));
    req0_valid = 1'b0;
    @(negedge clk);
    chk("oob_count_sat", 32'(oob_count), 255);
    @(posedge clk); #1;

    // Reset while in RUN after writes: the sweep restarts and clears everything.
    do_reset();
    wait_init("init_cycles_run_reset");
    for (int a = 0; a < DEPTH; a++) rd(a, '0);

    // Both requesters valid for 6 cycles. After reset the pointer favours requester 0, so grants alternate.
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
    end
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1'b1;
      req0_addr  = AW'(k0);
      req0_data  = 32'hA0 + DW'(k0);
      req1_valid = 1'b1;
      req1_addr  = AW'(3 + k1);
      req1_data  = 32'hB0 + DW'(k1);
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      @(posedge clk); #1;
      if (g0) k0++;
      if (g1) k1++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    e = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) rd(a, e[a]);

    // Reset asserted mid-sweep, when the sweep index is 3.
    do_reset();
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset();
    wait_init("init_cycles_midsweep");
    for (int a = 0; a < DEPTH; a++) rd(a, '0);
    chk("oob_count_final", 32'(oob_count), 0);

    @(posedge clk); #1;
    chk("grants_left", 32'(exp_gnt.size()), 0);
    chk("reads_left",  32'(exp_rd.size()),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
